// File: rtl/data_mem_pkg.sv
// Shared types and default sizing for the synchronous data memory.
package data_mem_pkg;

  localparam int unsigned DEFAULT_DATA_W = 16;
  localparam int unsigned DEFAULT_DEPTH  = 256;
  localparam int unsigned DEFAULT_ADDR_W = 16;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } mem_state_e;

  // Word-index width; a single-word array still needs one index bit.
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Byte-lane-write, synchronous-read RAM. Address is always in range when enabled.
module mem_array #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned IDX_W  = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [IDX_W-1:0]      addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic                  re,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array and its read register have no reset so they map onto a RAM macro;
  // zeroing is done by the controller's clear sweep instead.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DATA_W / 8; i++) begin
        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_memory_sync.sv
// Request/response data memory with a post-reset zero-fill sweep and 1-cycle latency.
module data_memory_sync
  import data_mem_pkg::*;
#(
  parameter int unsigned DATA_W         = DEFAULT_DATA_W,
  parameter int unsigned DEPTH          = DEFAULT_DEPTH,
  parameter int unsigned ADDR_W         = DEFAULT_ADDR_W,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [DATA_W/8-1:0]   req_be,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  init_done
);

  localparam int unsigned      IDX_W       = idx_width(DEPTH);
  localparam logic [ADDR_W:0]  DEPTH_EXT   = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(DEPTH - 1);
  localparam mem_state_e       RESET_STATE = CLEAR_ON_RESET ? CLEAR : READY;

  mem_state_e        state, state_next;
  logic [IDX_W-1:0]  clr_cnt, clr_cnt_next;
  logic              accept, in_range, clearing, rd_sel;

  logic                 mem_we, mem_re;
  logic [DATA_W/8-1:0]  mem_be;
  logic [IDX_W-1:0]     mem_addr;
  logic [DATA_W-1:0]    mem_wdata, mem_rdata;

  assign req_ready = (state == READY);
  assign init_done = (state == READY);
  assign in_range  = ({1'b0, req_addr} < DEPTH_EXT);
  // A request coinciding with rst is dropped: no write, no response.
  assign accept    = req_valid && req_ready && !rst;
  assign clearing  = (state == CLEAR) && !rst;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    if (clearing) begin
      if (clr_cnt == LAST_IDX) state_next   = READY;
      else                     clr_cnt_next = clr_cnt + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RESET_STATE;
      clr_cnt <= '0;
    end else begin
      state   <= state_next;
      clr_cnt <= clr_cnt_next;
    end
  end

  // The sweep owns the RAM port while clearing; requests cannot be accepted then.
  always_comb begin
    mem_we    = accept && req_we && in_range;
    mem_re    = accept && !req_we && in_range;
    mem_be    = req_be;
    mem_addr  = req_addr[IDX_W-1:0];
    mem_wdata = req_wdata;
    if (clearing) begin
      mem_we    = 1'b1;
      mem_be    = '1;
      mem_addr  = clr_cnt;
      mem_wdata = '0;
    end
  end

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem_array (
    .clk   (clk),
    .we    (mem_we),
    .be    (mem_be),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .re    (mem_re),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rd_sel    <= 1'b0;
    end else begin
      rsp_valid <= accept;
      if (accept) begin
        rsp_err <= !in_range;
        rd_sel  <= !req_we && in_range;
      end
    end
  end

  // RAM read register only loads on in-range reads, so both terms hold between responses.
  assign rsp_rdata = rd_sel ? mem_rdata : '0;

endmodule

// File: doc/data_memory_sync.md
DATA_MEMORY_SYNC -- requirements
Module: data_memory_sync

Interface
REQ-001 Parameter DATA_W, default 16: data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 256: number of words implemented.
REQ-003 Parameter ADDR_W, default 16: request address width; SHALL satisfy 2**ADDR_W >= DEPTH.
REQ-004 Parameter CLEAR_ON_RESET, default 1: 1 = zero-fill the array after reset; 0 = skip the fill and keep array contents.
REQ-005 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 Port req_valid, input, 1 bit: a request is presented.
REQ-008 Port req_ready, output, 1 bit: the block can accept a request this cycle.
REQ-009 Port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-010 Port req_be, input, DATA_W/8 bits: byte-lane write enables; ignored on reads.
REQ-011 Port req_addr, input, ADDR_W bits: word address.
REQ-012 Port req_wdata, input, DATA_W bits: write data.
REQ-013 Port rsp_valid, output, 1 bit: one-cycle response pulse.
REQ-014 Port rsp_rdata, output, DATA_W bits: read data.
REQ-015 Port rsp_err, output, 1 bit: out-of-range address flag, qualified by rsp_valid.
REQ-016 Port init_done, output, 1 bit: high once the array is usable.

Function
REQ-017 FSM states SHALL be CLEAR and READY; rst forces CLEAR when CLEAR_ON_RESET=1, otherwise READY.
REQ-018 In CLEAR, a counter SHALL write all-zero to word 0..DEPTH-1, one word per cycle, then enter READY; CLEAR therefore lasts exactly DEPTH cycles.
REQ-019 req_ready and init_done SHALL be 1 only in READY; requests in CLEAR are not accepted.
REQ-020 A request is accepted on a rising edge where req_valid && req_ready.
REQ-021 Accepted write, addr < DEPTH: byte lane i is updated on the accepting edge only where req_be[i]=1; other lanes keep their value.
REQ-022 Any accepted request SHALL produce rsp_valid=1 in the following cycle only; latency is 1 cycle; one request per cycle is sustained.
REQ-023 Read response: rsp_rdata holds the word contents after all writes accepted on earlier edges; a write followed by a read to the same address on the next cycle returns the new data.
REQ-024 On write responses, rsp_rdata SHALL be 0.
REQ-025 Out of range (addr >= DEPTH): the write is suppressed, read data is 0, and rsp_err=1 with the response; otherwise rsp_err=0.
REQ-026 rsp_rdata and rsp_err SHALL hold their value until the next response; rsp_valid=0 on cycles with no accepted request.
REQ-027 Clear-counter width is $clog2(DEPTH), or 1 when DEPTH=1; the counter saturates at DEPTH-1 and never writes past it.

Reset
REQ-028 On rst: rsp_valid=0, rsp_rdata=0, rsp_err=0, clear counter=0, and FSM per REQ-017.
REQ-029 rst asserted during CLEAR SHALL restart the fill at word 0.
REQ-030 A request pending in the same cycle as rst SHALL be discarded with no write and no response.
REQ-031 Array contents are not reset directly; they are zeroed only by CLEAR.

Structure
REQ-032 Package data_mem_pkg SHALL hold the FSM state enum (CLEAR, READY) and default-width localparams.
REQ-033 Sub-module mem_array: a byte-lane-write, synchronous-read RAM of DEPTH x DATA_W; data_memory_sync drives it from the FSM or from the request port.

Verification
REQ-034 Preload 0xFFFF everywhere, rst pulse, CLEAR_ON_RESET=1 -> init_done rises after exactly DEPTH cycles; a read of every word returns 0x0000 with rsp_err=0.
REQ-035 Write 0x1234, be=11, addr 5; then write 0xAB00, be=10, addr 5; then read addr 5 -> rdata 0xAB34, one cycle after the read is accepted.
REQ-036 Back-to-back: write 0x5A5A to addr 7, then read addr 7 on the next cycle -> rsp_valid on two consecutive cycles; second response returns 0x5A5A.
REQ-037 Write 0xBEEF to addr 256 (DEPTH=256), then read addr 256 -> rsp_err=1 both times, rdata 0, no array word modified.
REQ-038 Assert rst at clear count 100 -> the fill restarts at word 0; init_done rises DEPTH cycles after rst is released.
REQ-039 req_valid held high during CLEAR -> no acceptance and no rsp_valid until READY; the first acceptance occurs on the first READY cycle.
